// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues single-word reads to instruction memory and
// buffers returned words with their PC in a small FIFO for decode.
module inst_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_addr_i,
  input  logic            redirect_i,
  output logic            pc_advance_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i,
  output logic            fetch_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Misalignment is flagged before the fill level is considered so an
        // illegal PC is reported even while decode is stalled.
        if (!redirect_i) begin
          if (fetch_addr_i[1:0] != 2'b00) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (!fifo_full) begin
            state_d = REQ;
            addr_d  = fetch_addr_i;
          end
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          state_d = IDLE;
          push    = !redirect_i;
        end else if (redirect_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack_i) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        if (redirect_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = !fifo_empty && inst_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

  assign imem_req_o   = (state_q == REQ) || (state_q == DROP);
  assign imem_addr_o  = addr_q;
  assign pc_advance_o = push;
  assign inst_valid_o = !fifo_empty;
  assign inst_data_o  = fifo_empty ? '0 : data_mem[rd_ptr_q];
  assign inst_pc_o    = fifo_empty ? '0 : pc_mem[rd_ptr_q];
  assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit: drives the PC, memory and
// decode sides cycle by cycle and compares against hand-computed values.
module tb_inst_fetch_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] fetchAddr;
  logic            redirect;
  logic            pcAdvance;
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemAck;
  logic [XLEN-1:0] imemRdata;
  logic            instValid;
  logic [XLEN-1:0] instData;
  logic [XLEN-1:0] instPc;
  logic            instReady;
  logic            fetchErr;

  int testCount;
  int failCount;

  inst_fetch_unit #(.DEPTH(2), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_addr_i (fetchAddr),
    .redirect_i   (redirect),
    .pc_advance_o (pcAdvance),
    .imem_req_o   (imemReq),
    .imem_addr_o  (imemAddr),
    .imem_ack_i   (imemAck),
    .imem_rdata_i (imemRdata),
    .inst_valid_o (instValid),
    .inst_data_o  (instData),
    .inst_pc_o    (instPc),
    .inst_ready_i (instReady),
    .fetch_err_o  (fetchErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [XLEN-1:0] addr, input logic redir,
                               input logic ack, input logic [XLEN-1:0] rdata,
                               input logic ready);
    fetchAddr = addr;
    redirect  = redir;
    imemAck   = ack;
    imemRdata = rdata;
    instReady = ready;
    #1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst_n     = 1'b0;
    fetchAddr = '0;
    redirect  = 1'b0;
    imemAck   = 1'b0;
    imemRdata = '0;
    instReady = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_req", imemReq, 0);
    checkOutput("rst_addr", imemAddr, 0);
    checkOutput("rst_pcadv", pcAdvance, 0);
    checkOutput("rst_valid", instValid, 0);
    checkOutput("rst_data", instData, 0);
    checkOutput("rst_pc", instPc, 0);
    checkOutput("rst_err", fetchErr, 0);
    tick();
    rst_n = 1'b1;

    // First fetch with zero-wait ack
    tick();
    applyStimulus(32'h0, 0, 1, 32'h2008_0005, 0);
    checkOutput("t1_req", imemReq, 1);
    checkOutput("t1_addr", imemAddr, 32'h0);
    checkOutput("t1_pcadv", pcAdvance, 1);
    tick();
    applyStimulus(32'h4, 0, 0, 0, 0);
    checkOutput("t1_req_drop", imemReq, 0);
    checkOutput("t1_pcadv_off", pcAdvance, 0);
    checkOutput("t1_valid", instValid, 1);
    checkOutput("t1_instpc", instPc, 32'h0);
    checkOutput("t1_instdata", instData, 32'h2008_0005);

    // Decode stalled: buffer fills at two entries
    tick();
    applyStimulus(32'h4, 0, 1, 32'hA4, 0);
    checkOutput("t2_addr4", imemAddr, 32'h4);
    checkOutput("t2_pcadv4", pcAdvance, 1);
    tick();
    applyStimulus(32'h8, 0, 0, 0, 0);
    checkOutput("t2_head0", instPc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_full_noreq", imemReq, 0);
      checkOutput("t2_full_head", instPc, 32'h0);
    end
    applyStimulus(32'h8, 0, 0, 0, 1);
    tick();
    checkOutput("t2_pop_pc4", instPc, 32'h4);
    checkOutput("t2_pop_data4", instData, 32'hA4);
    checkOutput("t2_pop_noreq", imemReq, 0);
    tick();
    checkOutput("t2_empty", instValid, 0);
    checkOutput("t2_req8", imemReq, 1);
    checkOutput("t2_addr8", imemAddr, 32'h8);
    applyStimulus(32'h8, 0, 1, 32'hA8, 1);
    checkOutput("t2_pcadv8", pcAdvance, 1);
    tick();
    applyStimulus(32'hC, 0, 0, 0, 0);
    checkOutput("t2_valid8", instValid, 1);
    checkOutput("t2_pc8", instPc, 32'h8);
    applyStimulus(32'hC, 0, 0, 0, 1);
    tick();
    applyStimulus(32'hC, 0, 0, 0, 0);
    checkOutput("t3_popped8", instValid, 0);
    checkOutput("t3_reqC", imemReq, 1);
    checkOutput("t3_addrC", imemAddr, 32'hC);

    // Late ack with redirect mid-request: dropped, then refetch at 0x40
    tick();
    applyStimulus(32'h40, 1, 0, 0, 0);
    checkOutput("t3_redir_pcadv", pcAdvance, 0);
    tick();
    applyStimulus(32'h40, 0, 0, 0, 0);
    checkOutput("t3_drop_req", imemReq, 1);
    checkOutput("t3_drop_addr", imemAddr, 32'hC);
    tick();
    applyStimulus(32'h40, 0, 1, 32'hDEAD_BEEF, 0);
    checkOutput("t3_late_pcadv", pcAdvance, 0);
    checkOutput("t3_late_addr", imemAddr, 32'hC);
    tick();
    applyStimulus(32'h40, 0, 0, 0, 0);
    checkOutput("t3_idle_req", imemReq, 0);
    checkOutput("t3_nopush", instValid, 0);
    tick();
    checkOutput("t3_req40", imemReq, 1);
    checkOutput("t3_addr40", imemAddr, 32'h40);
    applyStimulus(32'h40, 0, 1, 32'hB0, 0);
    checkOutput("t3_pcadv40", pcAdvance, 1);
    tick();
    applyStimulus(32'h44, 0, 0, 0, 0);
    tick();
    applyStimulus(32'h44, 0, 1, 32'hB4, 0);
    checkOutput("t4_addr44", imemAddr, 32'h44);
    tick();
    applyStimulus(32'h48, 0, 0, 0, 0);
    checkOutput("t4_full_valid", instValid, 1);
    checkOutput("t4_full_pc", instPc, 32'h40);
    checkOutput("t4_full_data", instData, 32'hB0);

    // Redirect with ready=1 flushes both entries; target is misaligned
    applyStimulus(32'h6, 1, 0, 0, 1);
    tick();
    applyStimulus(32'h6, 0, 0, 0, 0);
    checkOutput("t4_flush_valid", instValid, 0);
    checkOutput("t4_flush_data", instData, 0);
    checkOutput("t4_flush_req", imemReq, 0);
    checkOutput("t5_err_pre", fetchErr, 0);
    tick();
    checkOutput("t5_err_set", fetchErr, 1);
    checkOutput("t5_err_noreq", imemReq, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("t5_err_hold", fetchErr, 1);
      checkOutput("t5_err_hold_noreq", imemReq, 0);
    end
    applyStimulus(32'h10, 1, 0, 0, 0);
    tick();
    applyStimulus(32'h10, 0, 0, 0, 0);
    checkOutput("t5_err_clear", fetchErr, 0);
    checkOutput("t5_redir_noreq", imemReq, 0);
    tick();
    checkOutput("t5_req10", imemReq, 1);
    checkOutput("t5_addr10", imemAddr, 32'h10);

    // Asynchronous reset in the middle of a request
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_req", imemReq, 0);
    checkOutput("t6_rst_addr", imemAddr, 0);
    checkOutput("t6_rst_pcadv", pcAdvance, 0);
    checkOutput("t6_rst_err", fetchErr, 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(32'h0, 0, 1, 32'h1234, 0);
    checkOutput("t6_idle_ack_pcadv", pcAdvance, 0);
    tick();
    applyStimulus(32'h0, 0, 0, 32'h1234, 0);
    checkOutput("t6_req", imemReq, 1);
    checkOutput("t6_noack_pcadv", pcAdvance, 0);
    applyStimulus(32'h0, 0, 1, 32'h1234, 0);
    checkOutput("t6_ack_pcadv", pcAdvance, 1);
    tick();
    applyStimulus(32'h4, 0, 0, 0, 0);
    checkOutput("t6_valid", instValid, 1);
    checkOutput("t6_data", instData, 32'h1234);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
